// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
// Shared constants, state encoding and helpers for the board-check sequencer.
// - Board geometry (box edge, values per group, cell and group counts)
// - Group index bases: rows 0..8, columns 9..17, boxes 18..26
// - FG_NONE: fail_group value meaning "no failing group"
// - value_bit(): one-hot seen-mask bit for a cell value, zero when illegal
// -----------------------------------------------------------------------------
package sudoku_pkg;

  localparam int BOX_EDGE = 3;
  localparam int N        = BOX_EDGE * BOX_EDGE;
  localparam int N_CELLS  = N * N;
  localparam int N_GROUPS = 3 * N;

  localparam logic [4:0] FG_NONE = 5'h1F;

  localparam logic [4:0] G_ROW = 5'd0;
  localparam logic [4:0] G_COL = 5'd9;
  localparam logic [4:0] G_BOX = 5'd18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot bit (v-1) for a legal value 1..9; empty (0) or out-of-range
  // values return 0 so they never mark anything as seen.
  function automatic logic [8:0] value_bit(input logic [3:0] v);
    value_bit = 9'd0;
    if (v >= 4'd1 && v <= 4'd9) begin
      value_bit = 9'd1 << (v - 4'd1);
    end
  endfunction

endpackage

// File: rtl/sudoku_check_seq_group_addr.sv
// -----------------------------------------------------------------------------
// sudoku_group_addr
// Combinational mapping from (group, element) to a board cell address.
// Ports:
//   i_group  in  5   group index 0..26 (rows, then columns, then boxes)
//   i_elem   in  4   element index 0..8 within the group
//   o_addr   out CW  cell index row*9 + col
// -----------------------------------------------------------------------------
module sudoku_group_addr
  import sudoku_pkg::*;
#(
  parameter int CW = 7
) (
  input  logic [4:0]    i_group,
  input  logic [3:0]    i_elem,
  output logic [CW-1:0] o_addr
);

  int w_g;
  int w_k;
  int w_b;
  int w_a;

  always_comb begin
    w_g = int'(i_group);
    w_k = int'(i_elem);
    w_b = 0;
    if (w_g < int'(G_COL)) begin
      // row g, column k
      w_a = w_g * N + w_k;
    end else if (w_g < int'(G_BOX)) begin
      // column g-9, row k
      w_a = w_k * N + (w_g - int'(G_COL));
    end else begin
      // box b walked row-major: k/3 selects the row inside the box
      w_b = w_g - int'(G_BOX);
      w_a = (BOX_EDGE * (w_b / BOX_EDGE) + w_k / BOX_EDGE) * N
          + BOX_EDGE * (w_b % BOX_EDGE) + w_k % BOX_EDGE;
    end
    o_addr = CW'(w_a);
  end

endmodule

// File: rtl/sudoku_check_seq.sv
// -----------------------------------------------------------------------------
// sudoku_check_seq
// Board-check sequencer: on start, reads all 81 cells group by group
// (9 rows, 9 columns, 9 boxes) and reports whether every group holds 1..9
// exactly once, plus the first failing group.
// Ports:
//   i_clka        in  1   clock, rising edge
//   i_restart     in  1   asynchronous active-high reset
//   i_start       in  1   check request, honoured in IDLE and DONE only
//   o_rd_en       out 1   board read strobe
//   o_rd_addr     out CW  cell address (0 when o_rd_en is low)
//   i_rd_data     in  VW  cell value, valid the cycle after the read
//   o_busy        out 1   high while scanning
//   o_done        out 1   one-cycle result pulse
//   o_solved      out 1   all groups valid; held until next start
//   o_fail_group  out 5   first failing group, 5'h1F when none; held
// -----------------------------------------------------------------------------
module sudoku_check_seq
  import sudoku_pkg::*;
#(
  parameter int BOX = 3,
  parameter int CW  = 7,
  parameter int VW  = 4
) (
  input  logic          i_clka,
  input  logic          i_restart,
  input  logic          i_start,
  output logic          o_rd_en,
  output logic [CW-1:0] o_rd_addr,
  input  logic [VW-1:0] i_rd_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_solved,
  output logic [4:0]    o_fail_group
);

  localparam logic [3:0] LAST_ELEM  = 4'(BOX * BOX - 1);
  localparam logic [4:0] LAST_GROUP = 5'(N_GROUPS - 1);

  state_t      r_state;
  logic [4:0]  r_group;
  logic [3:0]  r_elem;
  logic        r_issue_end;   // all 243 reads have been issued
  logic        r_vld;         // a read is in flight; its data arrives now
  logic        r_last;        // that read is the 9th of its group
  logic [4:0]  r_tag_group;   // group of the in-flight read
  logic [8:0]  r_mask;
  logic        r_bad;
  logic        r_busy;
  logic        r_done;
  logic        r_solved;
  logic [4:0]  r_fail_group;

  logic [CW-1:0] w_addr;
  logic [8:0]    w_bit;
  logic [8:0]    w_mask_next;
  logic          w_bad_next;
  logic          w_pass;

  sudoku_group_addr #(.CW(CW)) u_addr (
    .i_group (r_group),
    .i_elem  (r_elem),
    .o_addr  (w_addr)
  );

  assign w_bit       = value_bit(i_rd_data);
  assign w_mask_next = r_mask | w_bit;
  // Illegal value (no bit) or a repeat of an already-seen value poisons the group.
  assign w_bad_next  = r_bad | (w_bit == 9'd0) | (|(r_mask & w_bit));
  assign w_pass      = (w_mask_next == 9'h1FF) && !w_bad_next;

  assign o_rd_en      = (r_state == SCAN) && !r_issue_end;
  assign o_rd_addr    = o_rd_en ? w_addr : '0;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_solved     = r_solved;
  assign o_fail_group = r_fail_group;

  always_ff @(posedge i_clka or posedge i_restart) begin
    if (i_restart) begin
      r_state      <= IDLE;
      r_group      <= '0;
      r_elem       <= '0;
      r_issue_end  <= 1'b0;
      r_vld        <= 1'b0;
      r_last       <= 1'b0;
      r_tag_group  <= '0;
      r_mask       <= '0;
      r_bad        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_solved     <= 1'b0;
      r_fail_group <= FG_NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state      <= SCAN;
            r_busy       <= 1'b1;
            r_solved     <= 1'b0;
            r_fail_group <= FG_NONE;
            r_group      <= '0;
            r_elem       <= '0;
            r_issue_end  <= 1'b0;
            r_vld        <= 1'b0;
            r_last       <= 1'b0;
            r_tag_group  <= '0;
            r_mask       <= '0;
            r_bad        <= 1'b0;
          end
        end

        SCAN: begin
          // Issue side: tag the read going out this cycle, then advance (g, k).
          r_vld       <= o_rd_en;
          r_last      <= (r_elem == LAST_ELEM);
          r_tag_group <= r_group;
          if (o_rd_en) begin
            if (r_elem == LAST_ELEM) begin
              r_elem <= '0;
              if (r_group == LAST_GROUP) begin
                r_issue_end <= 1'b1;
              end else begin
                r_group <= r_group + 5'd1;
              end
            end else begin
              r_elem <= r_elem + 4'd1;
            end
          end

          // Check side: fold in the value returned for last cycle's read.
          if (r_vld) begin
            if (r_last) begin
              r_mask <= '0;
              r_bad  <= 1'b0;
              if (!w_pass) begin
                // Leaving SCAN drops the read still in flight.
                r_state      <= DONE;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_solved     <= 1'b0;
                r_fail_group <= r_tag_group;
              end else if (r_tag_group == LAST_GROUP) begin
                r_state      <= DONE;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_solved     <= 1'b1;
                r_fail_group <= FG_NONE;
              end
            end else begin
              r_mask <= w_mask_next;
              r_bad  <= w_bad_next;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_check_seq.sv
module tb_sudoku_check_seq;

  logic       clk = 1'b0;
  logic       restart;
  logic       start;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic [3:0] rd_data = 4'd0;
  logic       busy;
  logic       done;
  logic       solved;
  logic [4:0] fail_group;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] board [0:80];
  int         exp_addr [0:242];

  always #5 clk = ~clk;

  sudoku_check_seq #(.BOX(3), .CW(7), .VW(4)) dut (
    .i_clka       (clk),
    .i_restart    (restart),
    .i_start      (start),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_solved     (solved),
    .o_fail_group (fail_group)
  );

  // Board store with one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en) rd_data <= (rd_addr < 7'd81) ? board[rd_addr] : 4'd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected read order: rows, then columns, then boxes walked row-major.
  task automatic build_addr_list();
    int j;
    j = 0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin exp_addr[j] = r * 9 + c; j++; end
    for (int c = 0; c < 9; c++)
      for (int r = 0; r < 9; r++) begin exp_addr[j] = r * 9 + c; j++; end
    for (int br = 0; br < 3; br++)
      for (int bc = 0; bc < 3; bc++)
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++) begin
            exp_addr[j] = (3 * br + rr) * 9 + 3 * bc + cc;
            j++;
          end
  endtask

  // First group whose nine values are not exactly {1..9}; -1 if none.
  function automatic int first_bad();
    for (int g = 0; g < 27; g++) begin
      int cnt [16];
      bool_loop: begin end
      for (int v = 0; v < 16; v++) cnt[v] = 0;
      for (int k = 0; k < 9; k++) cnt[board[exp_addr[g * 9 + k]]]++;
      for (int v = 1; v <= 9; v++) if (cnt[v] != 1) return g;
    end
    return -1;
  endfunction

  task automatic load_valid();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        board[r * 9 + c] = 4'((3 * (r % 3) + r / 3 + c) % 9 + 1);
  endtask

  task automatic load_random();
    int perm [9];
    int tmp, x, kind, a, b;
    logic transpose;
    for (int i = 0; i < 9; i++) perm[i] = i + 1;
    for (int i = 8; i > 0; i--) begin
      x = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[x]; perm[x] = tmp;
    end
    transpose = 1'($urandom_range(1, 0));
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        x = (3 * (r % 3) + r / 3 + c) % 9;
        if (transpose) board[c * 9 + r] = 4'(perm[x]);
        else           board[r * 9 + c] = 4'(perm[x]);
      end
    kind = $urandom_range(3, 0);
    a = $urandom_range(80, 0);
    b = $urandom_range(80, 0);
    case (kind)
      1: begin tmp = board[a]; board[a] = board[b]; board[b] = 4'(tmp); end
      2: board[a] = 4'($urandom_range(15, 0));
      3: board[a] = board[(a / 9) * 9 + (a % 9 + 1) % 9];
      default: ;
    endcase
  endtask

  // hazard: 0 none, 1 extra start pulse in cycle 50, 2 restart in cycle 100
  task automatic run_scan(input string name, input int hazard);
    int fb, exp_done, exp_last, exp_fg;
    logic exp_solved;
    int rd_cnt, rd_first, rd_last, addr_err, busy_err, done_cnt, done_cyc;
    logic got_solved;
    logic [4:0] got_fg;
    fb         = first_bad();
    exp_solved = (fb < 0);
    exp_done   = (fb < 0) ? 245 : 9 * fb + 11;
    exp_fg     = (fb < 0) ? 31 : fb;
    exp_last   = (exp_done - 1 > 243) ? 243 : exp_done - 1;
    rd_cnt = 0; rd_first = 0; rd_last = 0; addr_err = 0; busy_err = 0;
    done_cnt = 0; done_cyc = 0; got_solved = 1'b0; got_fg = 5'd0;

    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    check({name, " cleared_solved"}, 32'(solved), 32'd0);
    check({name, " cleared_fg"}, 32'(fail_group), 32'd31);

    for (int c = 1; c <= 260; c++) begin
      if (hazard == 2 && c == 100) begin
        restart = 1'b1;
        #1;
        check({name, " rst_busy"}, 32'(busy), 32'd0);
        check({name, " rst_rd_en"}, 32'(rd_en), 32'd0);
        check({name, " rst_done"}, 32'(done), 32'd0);
        check({name, " rst_fg"}, 32'(fail_group), 32'd31);
        check({name, " rst_rd_cnt"}, 32'(rd_cnt), 32'd99);
        @(negedge clk); restart = 1'b0;
        $display("scan %s: restart in cycle 100, reads before restart %0d", name, rd_cnt);
        return;
      end
      if (rd_en) begin
        if (rd_first == 0) rd_first = c;
        rd_last = c;
        if (rd_cnt < 243 && int'(rd_addr) != exp_addr[rd_cnt]) addr_err++;
        rd_cnt++;
      end else if (rd_addr != 7'd0) addr_err++;
      if (busy !== (c < exp_done)) busy_err++;
      if (done) begin
        done_cnt++;
        done_cyc   = c;
        got_solved = solved;
        got_fg     = fail_group;
      end
      if (hazard == 1 && c == 50) start = 1'b1;
      if (hazard == 1 && c == 51) start = 1'b0;
      @(negedge clk);
    end

    check({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({name, " solved"}, 32'(got_solved), 32'(exp_solved));
    check({name, " fail_group"}, 32'(got_fg), 32'(exp_fg));
    check({name, " rd_first"}, 32'(rd_first), 32'd1);
    check({name, " rd_last"}, 32'(rd_last), 32'(exp_last));
    check({name, " rd_count"}, 32'(rd_cnt), 32'(exp_last));
    check({name, " addr_errors"}, 32'(addr_err), 32'd0);
    check({name, " busy_errors"}, 32'(busy_err), 32'd0);
    check({name, " held_solved"}, 32'(solved), 32'(exp_solved));
    check({name, " held_fg"}, 32'(fail_group), 32'(exp_fg));
    $display("scan %s: done cycle %0d (exp %0d) solved %0d fail_group %0d reads %0d",
             name, done_cyc, exp_done, got_solved, got_fg, rd_cnt);
  endtask

  initial begin
    build_addr_list();
    restart = 1'b1;
    start   = 1'b0;
    for (int i = 0; i < 81; i++) board[i] = 4'd0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rd_en", 32'(rd_en), 32'd0);
    check("reset rd_addr", 32'(rd_addr), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset solved", 32'(solved), 32'd0);
    check("reset fail_group", 32'(fail_group), 32'd31);
    restart = 1'b0;
    @(negedge clk);
    $display("reset: outputs checked");

    load_valid();
    run_scan("valid+start50", 1);

    load_valid();
    board[0] = 4'd5; board[1] = 4'd5;
    run_scan("row0_dup", 0);

    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) board[r * 9 + c] = 4'(c + 1);
    run_scan("rows_only", 0);

    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) board[r * 9 + c] = 4'((r + c) % 9 + 1);
    run_scan("latin", 0);

    load_valid();
    board[80] = 4'd0;
    run_scan("cell80_empty", 0);

    load_valid();
    run_scan("restart100", 2);
    run_scan("after_restart", 0);

    for (int i = 0; i < 6; i++) begin
      load_random();
      run_scan($sformatf("random%0d", i), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
